// File: rtl/cfg_reg_loader.sv
// cfg_reg_loader: parses header/payload packets from the config FIFO
// into a flat bank of configuration registers.
//
// state | meaning
// ------+----------------------------------------------------------
// HDR   | idle; next accepted wr word is parsed as a packet header
// LOAD  | writing payload words at ptr, rem words still to come
// DONE  | one-cycle completion; pulses cfg_done, ignores wr
module cfg_reg_loader #(
    parameter int DATA_W = 32,
    parameter int N_REGS = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        din,
    input  logic                     start,
    output logic                     endldcr,
    output logic [N_REGS*DATA_W-1:0] cfg_regs,
    output logic                     cfg_done,
    output logic                     cfg_valid,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [8:0]          r_rem;
    logic [DATA_W-1:0]   r_regs [N_REGS];
    logic                r_err;
    logic                r_valid;

    logic [7:0]          w_cnt;
    logic [ADDR_W-1:0]   w_base;
    logic                w_cnt_ok;
    logic                w_accept;

    assign w_cnt    = din[15:8];
    assign w_base   = din[ADDR_W-1:0];
    assign w_cnt_ok = (w_cnt != 8'd0) && ({1'b0, w_cnt} <= 9'(N_REGS));
    // start always wins over wr; a word is only consumed when start is low
    assign w_accept = wr && !start;

    // State register; reset abandons any packet in flight immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_accept && w_cnt_ok) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    w_state_nxt = ST_HDR;
                end else if (wr && (r_rem == 9'd1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_HDR;
            end
            default: begin
                w_state_nxt = ST_HDR;
            end
        endcase
    end

    // Datapath: header latch, payload writes, sticky error and valid flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_accept) begin
                        if (w_cnt_ok) begin
                            r_ptr <= w_base;
                            r_rem <= {1'b0, w_cnt};
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (start) begin
                        r_err <= 1'b1;
                    end else if (wr && (r_rem != 9'd0)) begin
                        r_regs[r_ptr] <= din;
                        r_ptr         <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_rem         <= r_rem - 9'd1;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the register array onto the output bus
    for (genvar g = 0; g < N_REGS; g++) begin : g_flat
        assign cfg_regs[g*DATA_W +: DATA_W] = r_regs[g];
    end

    // endldcr ignores wr so upstream can stop reading the FIFO in the same cycle
    assign endldcr   = (r_state == ST_LOAD) && (r_rem == 9'd1) && !start;
    assign cfg_done  = (r_state == ST_DONE);
    assign cfg_valid = r_valid;
    assign busy      = (r_state != ST_HDR);
    assign err       = r_err;

endmodule

// File: tb/tb_cfg_reg_loader.sv
// Testbench for cfg_reg_loader: vector table plus hand-written corner cases.
module tb_cfg_reg_loader;

    localparam int DATA_W = 32;
    localparam int N_REGS = 16;
    localparam int ADDR_W = 4;
    localparam int NV     = 21;

    logic                     clk;
    logic                     reset;
    logic                     wr;
    logic [DATA_W-1:0]        din;
    logic                     start;
    logic                     endldcr;
    logic [N_REGS*DATA_W-1:0] cfg_regs;
    logic                     cfg_done;
    logic                     cfg_valid;
    logic                     busy;
    logic                     err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic        start;
        logic [31:0] din;
        logic        e_endl;
        logic        e_done;
        logic        e_busy;
        logic        e_err;
        logic        e_valid;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] exp_regs [N_REGS];

    cfg_reg_loader #(
        .DATA_W(DATA_W),
        .N_REGS(N_REGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .din      (din),
        .start    (start),
        .endldcr  (endldcr),
        .cfg_regs (cfg_regs),
        .cfg_done (cfg_done),
        .cfg_valid(cfg_valid),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return cfg_regs[i*DATA_W +: DATA_W];
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < N_REGS; i++) begin
            check($sformatf("%s reg[%0d]", tag, i), reg_at(i), exp_regs[i]);
        end
    endtask

    // drive on negedge, let the active edge happen, settle just after it
    task automatic step(input logic w, input logic s, input logic [31:0] d);
        @(negedge clk);
        wr = w; start = s; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; wr = 1'b0; start = 1'b0; din = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N_REGS; i++) exp_regs[i] = '0;
    endtask

    initial begin
        //          wr start din            endl done busy err valid
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0203, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_000B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0105, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0066, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_030F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_0106, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 32'h0000_0077, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 32'h0000_0107, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; wr = 1'b0; start = 1'b0; din = '0;
        for (int i = 0; i < N_REGS; i++) exp_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset endldcr", {31'd0, endldcr}, 32'd0);
        check("reset cfg_done", {31'd0, cfg_done}, 32'd0);
        check("reset cfg_valid", {31'd0, cfg_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check_all_regs("reset");
        @(negedge clk);
        reset = 1'b0;

        // basic packet, back-to-back, wrap-around, bad headers, start in DONE/HDR
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wr = vecs[i].wr; start = vecs[i].start; din = vecs[i].din;
            #1;
            check($sformatf("v%0d endldcr", i), {31'd0, endldcr}, {31'd0, vecs[i].e_endl});
            check($sformatf("v%0d cfg_done", i), {31'd0, cfg_done}, {31'd0, vecs[i].e_done});
            check($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
            check($sformatf("v%0d cfg_valid", i), {31'd0, cfg_valid}, {31'd0, vecs[i].e_valid});
            @(posedge clk);
        end
        exp_regs[3]  = 32'hA;
        exp_regs[4]  = 32'hB;
        exp_regs[5]  = 32'h55;
        exp_regs[15] = 32'h1;
        exp_regs[0]  = 32'h2;
        exp_regs[1]  = 32'h3;
        exp_regs[6]  = 32'h77;
        #1;
        check_all_regs("table");

        // abort by start after two of four payload words
        do_reset();
        step(1'b1, 1'b0, 32'h0000_0408);
        step(1'b1, 1'b0, 32'h0000_0011);
        check("latency reg[8]", reg_at(8), 32'h11);
        step(1'b1, 1'b0, 32'h0000_0022);
        @(negedge clk);
        wr = 1'b1; start = 1'b1; din = 32'h0000_0033;
        #1;
        check("abort busy before", {31'd0, busy}, 32'd1);
        check("abort err before", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort err", {31'd0, err}, 32'd1);
        check("abort cfg_done", {31'd0, cfg_done}, 32'd0);
        step(1'b0, 1'b0, 32'h0);
        check("abort cfg_done later", {31'd0, cfg_done}, 32'd0);
        check("abort cfg_valid", {31'd0, cfg_valid}, 32'd0);
        exp_regs[8] = 32'h11;
        exp_regs[9] = 32'h22;
        check_all_regs("abort");

        // reset mid-packet after one of three words
        step(1'b1, 1'b0, 32'h0000_0300);
        step(1'b1, 1'b0, 32'h0000_0099);
        check("pre-reset reg[0]", reg_at(0), 32'h99);
        @(negedge clk);
        wr = 1'b0;
        reset = 1'b1;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset err", {31'd0, err}, 32'd0);
        check("async reset reg[0]", reg_at(0), 32'h0);
        check("async reset reg[8]", reg_at(8), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N_REGS; i++) exp_regs[i] = '0;
        step(1'b1, 1'b0, 32'h0000_0102);
        check("post-reset hdr busy", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b0, 32'h0000_005A);
        check("post-reset done", {31'd0, cfg_done}, 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check("post-reset valid", {31'd0, cfg_valid}, 32'd1);
        check("post-reset err", {31'd0, err}, 32'd0);
        exp_regs[2] = 32'h5A;
        check_all_regs("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_reg_loader.md
CFG_REG_LOADER -- requirements
Module: cfg_reg_loader

Interface
REQ-001 Parameter: DATA_W, default 32, width of a configuration word.
REQ-002 Parameter: N_REGS, default 16, number of configuration registers.
REQ-003 Parameter: ADDR_W, default 4, register index width; SHALL satisfy 2^ADDR_W = N_REGS.
REQ-004 Clock and reset SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr  in  1  write strobe from the upstream config FSM; din is valid when wr=1.
REQ-008 din  in  DATA_W  configuration word from the config FIFO.
REQ-009 start  in  1  accelerator run request; while high, no configuration SHALL be accepted.
REQ-010 endldcr  out  1  "end load config register": high during the cycle in which the last payload word of a packet is written.
REQ-011 cfg_regs  out  N_REGS*DATA_W  flat register bank; register i occupies bits [i*DATA_W +: DATA_W].
REQ-012 cfg_done  out  1  one-cycle pulse after a packet completes.
REQ-013 cfg_valid  out  1  level; high once at least one packet has completed since reset.
REQ-014 busy  out  1  high while a packet is in progress (state LOAD or DONE).
REQ-015 err  out  1  sticky error flag; cleared only by reset.

Function
REQ-016 The packet format SHALL be one header word followed by CNT payload words.
REQ-017 Header fields SHALL be: din[ADDR_W-1:0] = base index BASE; din[15:8] = CNT.
REQ-018 The FSM SHALL have three states: HDR (reset state), LOAD and DONE.
REQ-019 HDR, wr=1, start=0, 1<=CNT<=N_REGS: latch BASE into ptr and CNT into rem; go to LOAD.
REQ-020 HDR, wr=1, CNT=0 or CNT>N_REGS: set err; stay in HDR; discard the word.
REQ-021 LOAD, wr=1, start=0: cfg_regs[ptr] <= din; ptr <= ptr+1 (mod N_REGS, wraps 15->0 by default); rem <= rem-1.
REQ-022 LOAD, wr=1, rem=1: perform the write and go to DONE.
REQ-023 endldcr SHALL be combinational: (state=LOAD) AND (rem=1) AND (start=0), independent of wr, so the upstream FSM can suppress its next FIFO read in that same cycle.
REQ-024 LOAD, wr=0: hold all state; no timeout.
REQ-025 DONE SHALL last exactly one cycle: cfg_done=1, cfg_valid set, then go to HDR; wr during DONE SHALL be ignored (this absorbs the trailing strobe of the upstream FSM).
REQ-026 start=1 in LOAD SHALL abort the packet: go to HDR next cycle, set err, keep already-written registers, assert no cfg_done.
REQ-027 start=1 in HDR or DONE SHALL block header acceptance; DONE still completes normally.
REQ-028 A write to cfg_regs SHALL be visible on cfg_regs the cycle after the wr edge (one-cycle latency).
REQ-029 Registers not addressed by a packet SHALL retain their values.
REQ-030 rem SHALL be 9 bits wide; no arithmetic SHALL underflow.
REQ-031 wr=1 and start=1 in the same cycle: start takes priority and wr is ignored.

Reset
REQ-032 On reset: state=HDR; ptr=0; rem=0; all cfg_regs=0; endldcr=0; cfg_done=0; cfg_valid=0; busy=0; err=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet immediately (asynchronously); after release, the first wr word SHALL be treated as a header.

Verification
REQ-034 Header 0x0000_0203 then payload 0xA, 0xB: regs[3]=0xA, regs[4]=0xB; endldcr high on the 0xB write cycle; cfg_done pulses the next cycle; cfg_valid=1.
REQ-035 Header 0x0000_030F then payload 1, 2, 3: regs[15]=1, regs[0]=2, regs[1]=3 (wrap-around); all other registers unchanged.
REQ-036 Header with CNT=0, then header with CNT=17: err=1, state stays HDR, no register changes; a following valid packet still loads.
REQ-037 Header CNT=4, two payload words, then start=1: return to HDR, err=1, only 2 registers written, no cfg_done.
REQ-038 Back-to-back packets with wr held high through DONE: the DONE-cycle word is ignored, and the next wr word is parsed as a header.
REQ-039 Reset pulsed mid-packet after 1 of 3 words: all registers=0, flags=0; next word parsed as a header.
